// File: rtl/core_seq_pkg.sv
// Shared types and constants for the multi-cycle core sequencer.
// Optional build macro: CORE_SEQ_TRAP_ILLEGAL_EN (traps unlisted opcodes).
package core_seq_pkg;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEM       = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALT      = 3'd5,
      ST_TRAP      = 3'd6
   } state_t;

   // RV32I major opcodes, instruction[6:0]
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic PC_SEL_PLUS4  = 1'b0;
   localparam logic PC_SEL_TARGET = 1'b1;
   localparam logic ADDR_SEL_PC   = 1'b0;
   localparam logic ADDR_SEL_ALU  = 1'b1;

   // Instructions that finish through the WRITEBACK state
   function automatic logic is_wb_class(input logic [6:0] op);
      return (op == OPC_OP) || (op == OPC_OP_IMM) || (op == OPC_LUI) ||
             (op == OPC_AUIPC) || (op == OPC_JAL) || (op == OPC_JALR);
   endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Unified memory port shared by instruction fetch and load/store.
interface core_sequencer_if;
   logic mem_req;
   logic mem_we;
   logic mem_addr_sel;
   logic mem_ready;

   modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
   modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request waits for ready; flags expiry on the
// last allowed wait cycle. MEM_WAIT_MAX = 0 disables the timeout.
module mem_wait_timer #(
   parameter int MEM_WAIT_MAX = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   input  logic ready,
   output logic expired
);

   localparam int CNT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
   localparam bit TIMEOUT_EN = (MEM_WAIT_MAX > 0);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

   logic [CNT_W-1:0] count_reg;
   logic waiting;

   assign waiting = active && !ready;
   // count_reg holds the waits already seen, so this cycle is wait number count_reg+1
   assign expired = TIMEOUT_EN && waiting && (count_reg == LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (!waiting) begin
         count_reg <= '0;
      end else if (count_reg != LIMIT) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the RV32I core.
// Optional build macro: CORE_SEQ_TRAP_ILLEGAL_EN (unlisted opcodes trap).
module core_sequencer
   import core_seq_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 16,
   parameter int RETIRE_W     = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   core_sequencer_if.master    mem,
   input  logic [6:0]          opcode,
   input  logic                branch_taken,
   output logic                ir_wen,
   output logic                pc_wen,
   output logic                pc_sel,
   output logic                rf_commit,
   output logic                retired,
   output logic [RETIRE_W-1:0] retired_count,
   output logic                halted,
   output logic                bus_error,
`ifdef CORE_SEQ_TRAP_ILLEGAL_EN
   output logic                illegal_insn,
`endif
   output logic [2:0]          state_o
);

   state_t state_reg, state_next;
   logic [RETIRE_W-1:0] retired_count_reg;
   logic bus_error_reg;
   logic req, we, addr_sel;
   logic timer_expired;

   mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .active  (req),
      .ready   (mem.mem_ready),
      .expired (timer_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg         <= ST_FETCH;
         retired_count_reg <= '0;
         bus_error_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (retired) retired_count_reg <= retired_count_reg + RETIRE_W'(1);
         if (timer_expired) bus_error_reg <= 1'b1;
      end
   end

   // Strobes are gated by rst_n so they drop the instant reset asserts
   always_comb begin
      state_next = state_reg;
      req        = 1'b0;
      we         = 1'b0;
      addr_sel   = ADDR_SEL_PC;
      ir_wen     = 1'b0;
      pc_wen     = 1'b0;
      pc_sel     = PC_SEL_PLUS4;
      rf_commit  = 1'b0;
      retired    = 1'b0;
      halted     = 1'b0;
`ifdef CORE_SEQ_TRAP_ILLEGAL_EN
      illegal_insn = 1'b0;
`endif
      if (rst_n) begin
         unique case (state_reg)
            ST_FETCH: begin
               req    = 1'b1;
               ir_wen = mem.mem_ready;
               if (mem.mem_ready)    state_next = ST_DECODE;
               else if (timer_expired) state_next = ST_HALT;
            end
            ST_DECODE: state_next = ST_EXECUTE;
            ST_EXECUTE: begin
               if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
                  state_next = ST_MEM;
               end else if (opcode == OPC_SYSTEM) begin
                  state_next = ST_HALT;
               end else if (opcode == OPC_BRANCH) begin
                  pc_wen     = 1'b1;
                  pc_sel     = branch_taken;
                  retired    = 1'b1;
                  state_next = ST_FETCH;
               end else if (is_wb_class(opcode)) begin
                  state_next = ST_WRITEBACK;
               end else begin
`ifdef CORE_SEQ_TRAP_ILLEGAL_EN
                  state_next = ST_TRAP;
`else
                  pc_wen     = 1'b1;
                  pc_sel     = PC_SEL_PLUS4;
                  retired    = 1'b1;
                  state_next = ST_FETCH;
`endif
               end
            end
            ST_MEM: begin
               req      = 1'b1;
               addr_sel = ADDR_SEL_ALU;
               we       = (opcode == OPC_STORE);
               if (mem.mem_ready) begin
                  if (opcode == OPC_STORE) begin
                     pc_wen     = 1'b1;
                     retired    = 1'b1;
                     state_next = ST_FETCH;
                  end else begin
                     state_next = ST_WRITEBACK;
                  end
               end else if (timer_expired) begin
                  state_next = ST_HALT;
               end
            end
            ST_WRITEBACK: begin
               rf_commit  = 1'b1;
               pc_wen     = 1'b1;
               retired    = 1'b1;
               pc_sel     = (opcode == OPC_JAL || opcode == OPC_JALR) ? PC_SEL_TARGET : PC_SEL_PLUS4;
               state_next = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            ST_TRAP: begin
               halted = 1'b1;
`ifdef CORE_SEQ_TRAP_ILLEGAL_EN
               illegal_insn = 1'b1;
`endif
            end
            default: state_next = ST_FETCH;
         endcase
      end
   end

   assign mem.mem_req      = req;
   assign mem.mem_we       = we;
   assign mem.mem_addr_sel = addr_sel;
   assign retired_count    = retired_count_reg;
   assign bus_error        = bus_error_reg;
   assign state_o          = state_reg;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: hand vector table, random
// instruction stream against a per-instruction phase model, corner sequences.
module tb_core_sequencer;
   import core_seq_pkg::*;

   localparam int WAIT_MAX = 4;
   localparam int RW       = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [6:0]    opcode = '0;
   logic          branch_taken = 1'b0;
   logic          ir_wen, pc_wen, pc_sel, rf_commit, retired, halted, bus_error;
   logic [RW-1:0] retired_count;
   logic [2:0]    state_o;
`ifdef CORE_SEQ_TRAP_ILLEGAL_EN
   logic          illegal_insn;
`endif

   core_sequencer_if mem_bus ();

   core_sequencer #(.MEM_WAIT_MAX(WAIT_MAX), .RETIRE_W(RW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem           (mem_bus.master),
      .opcode        (opcode),
      .branch_taken  (branch_taken),
      .ir_wen        (ir_wen),
      .pc_wen        (pc_wen),
      .pc_sel        (pc_sel),
      .rf_commit     (rf_commit),
      .retired       (retired),
      .retired_count (retired_count),
      .halted        (halted),
      .bus_error     (bus_error),
`ifdef CORE_SEQ_TRAP_ILLEGAL_EN
      .illegal_insn  (illegal_insn),
`endif
      .state_o       (state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] op;
      logic       bt, rdy;
      logic [2:0] st;
      logic       req, we, asel, irw, pcw, pcs, rfc, ret, hlt, berr, ill;
   } vec_t;

   typedef enum int {C_ALU, C_JUMP, C_BRANCH, C_LOAD, C_STORE, C_SYSTEM, C_ILLEGAL} cls_t;

   int checks = 0;
   int failures = 0;
   int model_cnt = 0;
   vec_t tbl[$];

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endfunction

   function automatic logic rbit();
      return 1'($urandom);
   endfunction

   function automatic vec_t mk(input logic [2:0] st, input logic [6:0] op, input logic bt, input logic rdy,
                               input logic req, input logic we, input logic asel, input logic irw,
                               input logic pcw, input logic pcs, input logic rfc, input logic ret);
      vec_t x;
      x.st = st; x.op = op; x.bt = bt; x.rdy = rdy;
      x.req = req; x.we = we; x.asel = asel; x.irw = irw;
      x.pcw = pcw; x.pcs = pcs; x.rfc = rfc; x.ret = ret;
      x.hlt = (st == 3'd5) || (st == 3'd6);
      x.ill = (st == 3'd6);
      x.berr = 1'b0;
      return x;
   endfunction

   function automatic cls_t op_class(input logic [6:0] op);
      case (op)
         7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return C_ALU;
         7'b1101111, 7'b1100111: return C_JUMP;
         7'b1100011: return C_BRANCH;
         7'b0000011: return C_LOAD;
         7'b0100011: return C_STORE;
         7'b1110011: return C_SYSTEM;
         default:    return C_ILLEGAL;
      endcase
   endfunction

   // Called at a negedge: drive, settle, compare, advance to the next negedge
   task automatic apply(input vec_t v, input string tag);
      opcode = v.op;
      branch_taken = v.bt;
      mem_bus.mem_ready = v.rdy;
      #1;
      chk({tag, ".state"},     32'(state_o),      32'(v.st));
      chk({tag, ".mem_req"},   32'(mem_bus.mem_req), 32'(v.req));
      chk({tag, ".mem_we"},    32'(mem_bus.mem_we),  32'(v.we));
      chk({tag, ".addr_sel"},  32'(mem_bus.mem_addr_sel), 32'(v.asel));
      chk({tag, ".ir_wen"},    32'(ir_wen),       32'(v.irw));
      chk({tag, ".pc_wen"},    32'(pc_wen),       32'(v.pcw));
      if (v.pcw) chk({tag, ".pc_sel"}, 32'(pc_sel), 32'(v.pcs));
      chk({tag, ".rf_commit"}, 32'(rf_commit),    32'(v.rfc));
      chk({tag, ".retired"},   32'(retired),      32'(v.ret));
      chk({tag, ".halted"},    32'(halted),       32'(v.hlt));
      chk({tag, ".bus_error"}, 32'(bus_error),    32'(v.berr));
      chk({tag, ".count"},     32'(retired_count), 32'(model_cnt));
`ifdef CORE_SEQ_TRAP_ILLEGAL_EN
      chk({tag, ".illegal"},   32'(illegal_insn), 32'(v.ill));
`endif
      if (v.ret) model_cnt = (model_cnt + 1) % (1 << RW);
      @(negedge clk);
   endtask

   task automatic chk_in_reset(input string tag);
      chk({tag, ".state"},     32'(state_o), 32'd0);
      chk({tag, ".mem_req"},   32'(mem_bus.mem_req), 32'd0);
      chk({tag, ".mem_we"},    32'(mem_bus.mem_we), 32'd0);
      chk({tag, ".ir_wen"},    32'(ir_wen), 32'd0);
      chk({tag, ".pc_wen"},    32'(pc_wen), 32'd0);
      chk({tag, ".retired"},   32'(retired), 32'd0);
      chk({tag, ".count"},     32'(retired_count), 32'd0);
      chk({tag, ".halted"},    32'(halted), 32'd0);
      chk({tag, ".bus_error"}, 32'(bus_error), 32'd0);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      mem_bus.mem_ready = 1'b1;
      opcode = OPC_STORE;
      #1;
      chk_in_reset(tag);
      model_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset %s", tag);
   endtask

   // Expected behaviour of one instruction, phase by phase
   task automatic do_insn(input logic [6:0] op, input int fw, input int mw, input string tag);
      cls_t c;
      logic r, bt;
      c = op_class(op);
      for (int w = 0; w <= fw; w++) begin
         r = (w == fw);
         apply(mk(3'd0, 7'($urandom), rbit(), r, 1, 0, 0, r, 0, 0, 0, 0), {tag, ".fetch"});
      end
      apply(mk(3'd1, op, rbit(), rbit(), 0, 0, 0, 0, 0, 0, 0, 0), {tag, ".decode"});
      bt = rbit();
      case (c)
         C_ALU, C_JUMP: begin
            apply(mk(3'd2, op, bt, rbit(), 0, 0, 0, 0, 0, 0, 0, 0), {tag, ".exec"});
            apply(mk(3'd4, op, rbit(), rbit(), 0, 0, 0, 0, 1, c == C_JUMP, 1, 1), {tag, ".wb"});
         end
         C_BRANCH: apply(mk(3'd2, op, bt, rbit(), 0, 0, 0, 0, 1, bt, 0, 1), {tag, ".exec"});
         C_LOAD, C_STORE: begin
            apply(mk(3'd2, op, bt, rbit(), 0, 0, 0, 0, 0, 0, 0, 0), {tag, ".exec"});
            for (int w = 0; w <= mw; w++) begin
               r = (w == mw);
               if (c == C_STORE)
                  apply(mk(3'd3, op, rbit(), r, 1, 1, 1, 0, r, 0, 0, r), {tag, ".mem"});
               else
                  apply(mk(3'd3, op, rbit(), r, 1, 0, 1, 0, 0, 0, 0, 0), {tag, ".mem"});
            end
            if (c == C_LOAD)
               apply(mk(3'd4, op, rbit(), rbit(), 0, 0, 0, 0, 1, 0, 1, 1), {tag, ".wb"});
         end
         C_SYSTEM: apply(mk(3'd2, op, bt, rbit(), 0, 0, 0, 0, 0, 0, 0, 0), {tag, ".exec"});
         default: begin
`ifdef CORE_SEQ_TRAP_ILLEGAL_EN
            apply(mk(3'd2, op, bt, rbit(), 0, 0, 0, 0, 0, 0, 0, 0), {tag, ".exec"});
`else
            apply(mk(3'd2, op, bt, rbit(), 0, 0, 0, 0, 1, 0, 0, 1), {tag, ".exec"});
`endif
         end
      endcase
      $display("insn %s op=%07b fetch_waits=%0d mem_waits=%0d model_count=%0d", tag, op, fw, mw, model_cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] pool [12];
      int pool_n;
      vec_t v;
      pool = '{OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM,
               OPC_LUI, OPC_AUIPC, 7'b0001011, 7'b0001111, 7'b1111111};
`ifdef CORE_SEQ_TRAP_ILLEGAL_EN
      pool_n = 9;
`else
      pool_n = 12;
`endif
      mem_bus.mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      do_reset("initial");

      // ADDI, BEQ taken, LW with 3 MEM waits (ready on the limit cycle), SW zero-wait
      tbl.push_back(mk(3'd0, OPC_OP_IMM, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(3'd1, OPC_OP_IMM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(3'd2, OPC_OP_IMM, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(3'd4, OPC_OP_IMM, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1));
      tbl.push_back(mk(3'd0, OPC_BRANCH, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(3'd1, OPC_BRANCH, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(3'd2, OPC_BRANCH, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1));
      tbl.push_back(mk(3'd0, OPC_LOAD,   0, 1, 1, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(3'd1, OPC_LOAD,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(3'd2, OPC_LOAD,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(3'd3, OPC_LOAD,   0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(3'd3, OPC_LOAD,   0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(3'd3, OPC_LOAD,   0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(3'd3, OPC_LOAD,   0, 1, 1, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(3'd4, OPC_LOAD,   0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
      tbl.push_back(mk(3'd0, OPC_STORE,  0, 1, 1, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(3'd1, OPC_STORE,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(3'd2, OPC_STORE,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(3'd3, OPC_STORE,  0, 1, 1, 1, 1, 0, 1, 0, 0, 1));
      tbl.push_back(mk(3'd0, OPC_STORE,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));
      $display("table vectors=%0d model_count=%0d", tbl.size(), model_cnt);
      // DUT now in FETCH with one wait already counted; finish that fetch
      apply(mk(3'd0, 7'd0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0), "tblfin.fetch");
      apply(mk(3'd1, OPC_OP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "tblfin.decode");
      apply(mk(3'd2, OPC_OP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "tblfin.exec");
      apply(mk(3'd4, OPC_OP, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1), "tblfin.wb");

      for (int n = 0; n < 60; n++)
         do_insn(pool[$urandom_range(0, pool_n - 1)], $urandom_range(0, 3), $urandom_range(0, 3),
                 $sformatf("rnd%0d", n));

      // Reset in the middle of a waiting store
      if (model_cnt == 0) do_insn(OPC_OP_IMM, 0, 0, "pad");
      apply(mk(3'd0, 7'd0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0), "abort.fetch");
      apply(mk(3'd1, OPC_STORE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "abort.decode");
      apply(mk(3'd2, OPC_STORE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "abort.exec");
      apply(mk(3'd3, OPC_STORE, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0), "abort.mem");
      mem_bus.mem_ready = 1'b0;
      #1;
      chk("abort.pre_mem_we", 32'(mem_bus.mem_we), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_in_reset("abort.async");
      model_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset abort");
      do_insn(OPC_OP, 1, 0, "post_abort");

      // Unlisted opcode
      do_insn(7'b0001011, 0, 0, "custom0");
`ifdef CORE_SEQ_TRAP_ILLEGAL_EN
      for (int k = 0; k < 3; k++) apply(mk(3'd6, 7'b0001011, rbit(), rbit(), 0, 0, 0, 0, 0, 0, 0, 0), "trap");
      do_reset("after_trap");
`else
      apply(mk(3'd0, 7'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "custom0.back_to_fetch");
      apply(mk(3'd0, 7'd0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0), "custom0.fetch_done");
      apply(mk(3'd1, OPC_OP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "custom0.decode2");
      apply(mk(3'd2, OPC_OP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "custom0.exec2");
      apply(mk(3'd4, OPC_OP, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1), "custom0.wb2");
`endif

      // SYSTEM halts until reset
      do_insn(OPC_SYSTEM, 0, 0, "ecall");
      for (int k = 0; k < 3; k++) apply(mk(3'd5, OPC_SYSTEM, rbit(), rbit(), 0, 0, 0, 0, 0, 0, 0, 0), "halt");

      // Fetch timeout: four waits then HALT with bus_error
      do_reset("timeout");
      for (int w = 0; w < WAIT_MAX; w++)
         apply(mk(3'd0, 7'($urandom), rbit(), 0, 1, 0, 0, 0, 0, 0, 0, 0), $sformatf("tmo.wait%0d", w));
      for (int k = 0; k < 5; k++) begin
         v = mk(3'd5, 7'($urandom), rbit(), rbit(), 0, 0, 0, 0, 0, 0, 0, 0);
         v.berr = 1'b1;
         apply(v, $sformatf("tmo.halt%0d", k));
      end
      $display("timeout sequence done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
